// File: rtl/pk_t_unpack_pkg.sv
// Shared Kyber constants and payload types for the public-key t stream.
// Holds the ring/modulus parameters, derived beat geometry for the
// two-coefficients-per-beat unpacker, and the 12-bit range helper.
package pk_t_unpack_pkg;

    localparam int unsigned KYBER_N       = 256;
    localparam int unsigned KYBER_K       = 3;
    localparam int unsigned KYBER_R_WIDTH = 12;
    localparam int unsigned KYBER_Q       = 3329;

    localparam int unsigned POLY_BITS      = KYBER_N * KYBER_R_WIDTH;          // 3072
    localparam int unsigned T_BITS         = KYBER_K * POLY_BITS;              // 9216
    localparam int unsigned BEAT_BITS      = 2 * KYBER_R_WIDTH;                // 24
    localparam int unsigned BEAT_COUNT     = (KYBER_K * KYBER_N) / 2;          // 384
    localparam int unsigned BEATS_PER_POLY = KYBER_N / 2;                      // 128
    localparam int unsigned BEAT_CNT_W     = $clog2(BEAT_COUNT);               // 9
    localparam int unsigned BEAT_IN_POLY_W = $clog2(BEATS_PER_POLY);           // 7
    localparam int unsigned POLY_IDX_W     = BEAT_CNT_W - BEAT_IN_POLY_W;      // 2
    localparam int unsigned COEFF_IDX_W    = $clog2(KYBER_N);                  // 8

    typedef logic [KYBER_R_WIDTH-1:0] coeff_t;

    // One beat: even coefficient in the low half, odd coefficient in the high half.
    typedef struct packed {
        coeff_t hi;
        coeff_t lo;
    } coeff_pair_t;

    // Raw 12-bit value is a canonical residue mod q.
    function automatic logic coeff_in_range(coeff_t c);
        return c < KYBER_R_WIDTH'(KYBER_Q);
    endfunction

endpackage

// File: rtl/pk_t_unpack_if.sv
// Control and coefficient-stream bundle for pk_t_unpack.
// master: the unpacker (takes start/t_packed/coeff_ready, drives the stream).
// slave : the controller/consumer side (drives start/t_packed/coeff_ready).
interface pk_t_unpack_if;
    import pk_t_unpack_pkg::*;

    logic                   start;
    logic [T_BITS-1:0]      t_packed;
    logic                   busy;
    logic                   coeff_valid;
    logic                   coeff_ready;
    coeff_t                 coeff0;
    coeff_t                 coeff1;
    logic [POLY_IDX_W-1:0]  poly_idx;
    logic [COEFF_IDX_W-1:0] coeff_idx;
    logic                   done;
    logic                   key_err;

    modport master (
        input  start, t_packed, coeff_ready,
        output busy, coeff_valid, coeff0, coeff1, poly_idx, coeff_idx, done, key_err
    );

    modport slave (
        output start, t_packed, coeff_ready,
        input  busy, coeff_valid, coeff0, coeff1, poly_idx, coeff_idx, done, key_err
    );

endinterface

// File: rtl/pk_t_unpack_coeff_range_check.sv
// Combinational modulus check for one raw 12-bit coefficient.
// Ports: coeff (in, 12) value to test; in_range_c (out, 1) high when coeff < q.
module pk_t_unpack_coeff_range_check
    import pk_t_unpack_pkg::*;
(
    input  coeff_t coeff,
    output logic   in_range_c
);

    assign in_range_c = coeff_in_range(coeff);

endmodule

// File: rtl/pk_t_unpack.sv
// Streams the packed public-key vector t as 12-bit coefficients, two per
// beat, and flags any coefficient >= q with a sticky key_err.
// Ports: clk, rst (sync, active-high); bus (pk_t_unpack_if.master) carrying
// start/t_packed, busy, the coeff_valid/coeff_ready beat stream with
// coeff0/coeff1/poly_idx/coeff_idx, the done pulse and key_err.
module pk_t_unpack
    import pk_t_unpack_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    pk_t_unpack_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_n;

    logic [T_BITS-1:0]      shreg;
    logic [BEAT_CNT_W-1:0]  beat_cnt;
    logic                   valid_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   key_err_q;

    logic                   load_c;
    logic                   shift_c;
    logic                   last_c;
    logic                   in_range0_c;
    logic                   in_range1_c;
    coeff_pair_t            beat_c;

    // Current beat is always the low 24 bits of the shift register.
    assign beat_c = coeff_pair_t'(shreg[BEAT_BITS-1:0]);
    assign last_c = (beat_cnt == BEAT_CNT_W'(BEAT_COUNT - 1));

    pk_t_unpack_coeff_range_check u_chk0 (
        .coeff      (beat_c.lo),
        .in_range_c (in_range0_c)
    );

    pk_t_unpack_coeff_range_check u_chk1 (
        .coeff      (beat_c.hi),
        .in_range_c (in_range1_c)
    );

    // Next-state and datapath strobes.
    always_comb begin
        state_n = state;
        load_c  = 1'b0;
        shift_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load_c  = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                // coeff_valid is high for the whole RUN state.
                if (bus.coeff_ready) begin
                    shift_c = 1'b1;
                    if (last_c) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            valid_q <= (state_n == RUN);
            busy_q  <= (state_n != IDLE);
            done_q  <= (state_n == DONE);
        end
    end

    // Shift register, beat counter and sticky modulus error.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            beat_cnt  <= '0;
            key_err_q <= 1'b0;
        end else if (load_c) begin
            shreg     <= bus.t_packed;
            beat_cnt  <= '0;
            key_err_q <= 1'b0;
        end else if (shift_c) begin
            shreg     <= {BEAT_BITS'(0), shreg[T_BITS-1:BEAT_BITS]};
            // Wrap so indices read 0 again once the stream is complete.
            beat_cnt  <= last_c ? '0 : beat_cnt + BEAT_CNT_W'(1);
            key_err_q <= key_err_q | ~in_range0_c | ~in_range1_c;
        end
    end

    assign bus.coeff_valid = valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.key_err     = key_err_q;
    assign bus.coeff0      = beat_c.lo;
    assign bus.coeff1      = beat_c.hi;
    assign bus.poly_idx    = beat_cnt[BEAT_CNT_W-1:BEAT_IN_POLY_W];
    assign bus.coeff_idx   = {beat_cnt[BEAT_IN_POLY_W-1:0], 1'b0};

endmodule

// File: doc/pk_t_unpack.md
# pk_t_unpack

Streams the packed public-key vector t out as 12-bit coefficients, two per beat, under a valid/ready handshake. Sits directly downstream of the public-key decoder: it consumes the K×N×12-bit t field and feeds coefficients to the NTT-domain matrix-vector stage. It also performs the FIPS 203 encapsulation-key modulus check and raises a sticky error on any coefficient ≥ q.

## Interface
Parameters (shared package constants):
- KYBER_N, 256, coefficients per polynomial
- KYBER_K, 3, polynomials in t
- KYBER_R_WIDTH, 12, bits per packed coefficient
- KYBER_Q, 3329, modulus

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  capture t_packed and begin; ignored unless idle
- t_packed  in  KYBER_K*KYBER_R_WIDTH*KYBER_N (9216)  packed t vector
- busy  out  1  high from the cycle after an accepted start until done
- coeff_valid  out  1  beat available
- coeff_ready  in  1  consumer accepts beat
- coeff0  out  12  even coefficient of beat
- coeff1  out  12  odd coefficient of beat
- poly_idx  out  2  polynomial index 0..K-1 of current beat
- coeff_idx  out  8  index of coeff0 (always even)
- done  out  1  one-cycle pulse after last beat accepted
- key_err  out  1  sticky: some emitted coefficient ≥ KYBER_Q

## Operation
- Bit order: coefficient j of poly i = t_packed[i*3072 + j*12 +: 12]. Beat b (0..383) carries bits [b*24 +: 24]: coeff0 = low 12, coeff1 = high 12; poly_idx = b/128, coeff_idx = (b%128)*2.
- States: IDLE → RUN → DONE → IDLE.
  - IDLE: start=1 → load t_packed into shift register, clear beat counter and key_err, go RUN.
  - RUN: coeff_valid=1. On coeff_valid&coeff_ready: shift register right by 24, counter+1, key_err |= (coeff0 ≥ Q) | (coeff1 ≥ Q). Handshake on beat 383 → DONE.
  - DONE: done=1 for one cycle, → IDLE.
- Outputs are driven from the shift register's low 24 bits and the beat counter; no wide output mux.
- start while busy (RUN or DONE): ignored, no effect on capture or key_err.
- coeff_ready low: beat held stable (data, indices) until accepted; no bubbles are inserted by the block.
- Comparison is on raw 12-bit values; no reduction is applied, and values are emitted unchanged even when ≥ q.

## Timing
- Reset values: busy=0, coeff_valid=0, coeff0=coeff1=0, poly_idx=0, coeff_idx=0, done=0, key_err=0, state IDLE.
- start sampled at edge N → coeff_valid=1 with beat 0 from edge N+1.
- With coeff_ready held high: one beat per cycle, 384 cycles; done high in cycle N+385; busy low and IDLE again at N+386. New start accepted in IDLE cycle N+386.
- key_err is final when done pulses and holds until the next accepted start or rst.
- rst mid-RUN: next cycle all outputs at reset values; partial stream abandoned; consumer must discard.
- rst and start same cycle: rst wins.

## Structure
- KYBER_N, KYBER_K, KYBER_R_WIDTH, KYBER_Q, and localparams for beat count (K*N/2 = 384) and poly bits (3072) go in the shared Kyber package, alongside the public-key decoder's constants.
- State enum is local to the module.
- One natural sub-module: coeff_range_check (combinational 12-bit < KYBER_Q compare), instantiated twice; it is reused later by the ciphertext/secret-key decode paths.

## Test plan
- Counting pattern, coefficient j of poly i = (i*256+j) mod 3329, ready held high → 384 beats in order; beat 0 = (0,1), beat 128 = poly 1 coeff_idx 0 = (256,257); done in cycle N+385; key_err=0.
- Same vector, coeff_ready random 50% → identical coefficient sequence; outputs stable while stalled; done one cycle after final handshake.
- Poly 2 coeff 255 = 3329, all others 0 → key_err rises only after beat 383 is accepted and is 1 at done; coeff1 of beat 383 = 3329 emitted unmodified.
- All coefficients 0xFFF → key_err=1 after beat 0 is accepted; a following start with all-zero t → key_err cleared, stays 0.
- start pulsed at beat 100 with a different t_packed → ignored; stream continues from original data.
- rst asserted at beat 200 → next cycle coeff_valid=0, busy=0, key_err=0; fresh start restarts at beat 0.
